// File: rtl/q_ctrl_pkg.sv
// Shared types and constants for the Q-channel controller slice.
package q_ctrl_pkg;

    typedef enum logic [1:0] {
        Q_RUN     = 2'b00,
        Q_REQUEST = 2'b01,
        Q_STOPPED = 2'b10,
        Q_EXIT    = 2'b11
    } q_state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/q_channel_ctrl_if.sv
// Q-channel controller bundle: manager-side controls plus device Q-channel pins.
interface q_channel_ctrl_if #(
    parameter int CNT_W  = 8,
    parameter int STAT_W = 16
);
    logic              enable_i;
    logic [CNT_W-1:0]  idle_thresh_i;
    logic              wake_req_i;
    logic              qactive_i;
    logic              qacceptn_i;
    logic              qreqn_o;
    logic              clk_en_o;
    logic [1:0]        state_o;
    logic [STAT_W-1:0] stop_cnt_o;

    modport master (
        output enable_i, idle_thresh_i, wake_req_i, qactive_i, qacceptn_i,
        input  qreqn_o, clk_en_o, state_o, stop_cnt_o
    );

    modport slave (
        input  enable_i, idle_thresh_i, wake_req_i, qactive_i, qacceptn_i,
        output qreqn_o, clk_en_o, state_o, stop_cnt_o
    );
endinterface

// File: rtl/dff2_sync.sv
// Flop-chain synchroniser for an asynchronous single-bit input, reset to RESET_VAL.
module dff2_sync
    import q_ctrl_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {SYNC_DEPTH{RESET_VAL}};
        else       sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
    end

    assign q = sync_q[SYNC_DEPTH-1];
endmodule

// File: rtl/q_channel_ctrl.sv
// Q-channel controller: idle detection, quiescence request, clock gating and exit sequencing.
module q_channel_ctrl
    import q_ctrl_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int STAT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    q_channel_ctrl_if.slave q
);
    logic              qactive_s, qacceptn_s;
    logic [SYNC_DEPTH-1:0] vld_pipe;
    logic              sync_rdy, idle_now;
    q_state_t          state_q, state_d;
    logic              qreqn_q, qreqn_d, clk_en_q, clk_en_d;
    logic [CNT_W-1:0]  idle_cnt;
    logic [STAT_W-1:0] stop_cnt;

    dff2_sync #(.RESET_VAL(1'b0)) u_sync_qactive (
        .clk(clk), .reset(reset), .d(q.qactive_i), .q(qactive_s)
    );

    dff2_sync #(.RESET_VAL(1'b1)) u_sync_qacceptn (
        .clk(clk), .reset(reset), .d(q.qacceptn_i), .q(qacceptn_s)
    );

    // Synchronised pins are only trusted once real samples have filled the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[SYNC_DEPTH-2:0], 1'b1};
    end

    assign sync_rdy = vld_pipe[SYNC_DEPTH-1];
    assign idle_now = sync_rdy & q.enable_i & ~qactive_s & ~q.wake_req_i;

    always_comb begin
        state_d  = state_q;
        unique case (state_q)
            Q_RUN:     if (idle_now && qacceptn_s && idle_cnt == q.idle_thresh_i)
                           state_d = Q_REQUEST;
            Q_REQUEST: if (!qacceptn_s) state_d = Q_STOPPED;
            Q_STOPPED: if (qactive_s || q.wake_req_i || !q.enable_i) state_d = Q_EXIT;
            Q_EXIT:    if (qacceptn_s) state_d = Q_RUN;
            default:   state_d = Q_RUN;
        endcase
        qreqn_d  = !(state_d == Q_REQUEST || state_d == Q_STOPPED);
        clk_en_d = (state_d != Q_STOPPED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= Q_RUN;
            qreqn_q  <= 1'b1;
            clk_en_q <= 1'b1;
            idle_cnt <= '0;
            stop_cnt <= '0;
        end else begin
            state_q  <= state_d;
            qreqn_q  <= qreqn_d;
            clk_en_q <= clk_en_d;
            // Counter only runs in Q_RUN, so it is already zero on re-entry.
            if (state_q == Q_RUN && idle_now)
                idle_cnt <= (&idle_cnt) ? idle_cnt : idle_cnt + 1'b1;
            else
                idle_cnt <= '0;
            if (state_q == Q_REQUEST && state_d == Q_STOPPED && !(&stop_cnt))
                stop_cnt <= stop_cnt + 1'b1;
        end
    end

    assign q.qreqn_o    = qreqn_q;
    assign q.clk_en_o   = clk_en_q;
    assign q.state_o    = state_q;
    assign q.stop_cnt_o = stop_cnt;

    a_no_qreqn_rise: assert property (@(posedge clk) disable iff (reset)
        (state_q == Q_REQUEST) |-> !qreqn_q);
    a_gated_accepted: assert property (@(posedge clk) disable iff (reset)
        !clk_en_q |-> !qacceptn_s);
    a_run_not_accepted: assert property (@(posedge clk) disable iff (reset)
        (state_q == Q_RUN) |-> qacceptn_s);
endmodule
